// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: decodes a CPU request into one of NUM_REGIONS chip
// selects, inserts per-region wait states and returns a one-cycle response.
// Optional feature: define MEM_BUS_ERR_EN to report unmatched addresses as bus errors.
module mem_bus_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
    {32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
    {32'hFFFF_FFFF, 32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_F000},
  parameter logic [NUM_REGIONS*4-1:0] WAIT_STATES = 16'h0310
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [1:0]             req_size,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [1:0]             mem_size,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic [NUM_REGIONS-1:0] mem_cs,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   wr_q;
  logic [NUM_REGIONS-1:0] dec_cs;
  logic                   dec_hit;
  logic [3:0]             dec_wait;

  // Scan from the top index down so the lowest matching region overrides.
  always_comb begin
    dec_cs   = '0;
    dec_hit  = 1'b0;
    dec_wait = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((req_addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        dec_cs    = '0;
        dec_cs[i] = 1'b1;
        dec_hit   = 1'b1;
        dec_wait  = WAIT_STATES[i*4 +: 4];
      end
    end
`ifndef MEM_BUS_ERR_EN
    if (!dec_hit) begin
      dec_cs    = '0;
      dec_cs[0] = 1'b1;
      dec_wait  = WAIT_STATES[3:0];
    end
`endif
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_size  <= '0;
      mem_wdata <= '0;
      mem_cs    <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr  <= req_addr;
            mem_size  <= req_size;
            mem_wdata <= req_wdata;
            wr_q      <= req_write;
`ifdef MEM_BUS_ERR_EN
            if (!dec_hit) begin
              // No region claims the address: answer with an error, touch no memory.
              state     <= DONE;
              cnt       <= '0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
`else
            begin
`endif
              state  <= ACCESS;
              cnt    <= dec_wait;
              mem_cs <= dec_cs;
              mem_re <= ~req_write;
              mem_we <= req_write && (dec_wait == 4'd0);
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state     <= DONE;
            mem_cs    <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            if (!wr_q) rsp_rdata <= mem_rdata;
          end else begin
            // Strobe is registered, so raise it when entering the count==0 cycle.
            cnt    <= cnt - 4'd1;
            mem_we <= wr_q && (cnt == 4'd1);
          end
        end
        DONE: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: region decode, wait states, strobes,
// back-to-back requests, unmatched addresses and asynchronous reset abort.
module tb_mem_bus_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [63:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_cs;
  logic        mem_re, mem_we, busy;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [63:0] exp_rdata;

  always #5 clock = ~clock;

  mem_bus_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_cs(mem_cs), .mem_re(mem_re), .mem_we(mem_we),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge; checks every cycle of one transaction.
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input logic [3:0] cs, input int w, input logic err);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = 2'b10;
    req_wdata = wd;   mem_rdata = rd;
    chk({tag, "_ready"}, req_ready, 1'b1);
    @(negedge clock);
    req_valid = 1'b0;
    if (!err) begin
      chk({tag, "_addr"}, mem_addr, addr);
      chk({tag, "_size"}, mem_size, 2'b10);
      if (wr) chk({tag, "_wdata"}, mem_wdata, wd);
      for (int j = 0; j <= w; j++) begin
        chk({tag, "_cs"}, mem_cs, cs);
        chk({tag, "_re"}, mem_re, !wr);
        chk({tag, "_we"}, mem_we, wr && (j == w));
        chk({tag, "_vld_early"}, rsp_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b1);
        @(negedge clock);
      end
    end
    if (err) exp_rdata = '0;
    else if (!wr) exp_rdata = rd;
    chk({tag, "_vld"}, rsp_valid, 1'b1);
    chk({tag, "_err"}, rsp_err, err);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_cs_done"}, mem_cs, 4'b0000);
    chk({tag, "_strb_done"}, {mem_re, mem_we}, 2'b00);
    @(negedge clock);
    chk({tag, "_vld_pulse"}, rsp_valid, 1'b0);
    chk({tag, "_idle"}, req_ready, 1'b1);
    chk({tag, "_hold"}, rsp_rdata, exp_rdata);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = '0; req_wdata = '0; mem_rdata = '0; exp_rdata = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_vld", rsp_valid, 1'b0);
    chk("rst_cs", mem_cs, 4'b0000);
    chk("rst_rdata", rsp_rdata, 64'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_strb", {mem_re, mem_we}, 2'b00);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_txn("rd_r0", 1'b0, 32'h0000_0010, 64'h0, 64'h1122_3344_5566_7788, 4'b0001, 0, 1'b0);
    run_txn("wr_r2", 1'b1, 32'h8000_0004, 64'hAB, 64'hDEAD_BEEF_0000_0001, 4'b0100, 3, 1'b0);
    run_txn("rd_r3", 1'b0, 32'hFFFF_FFFF, 64'h0, 64'hCAFE_F00D_1234_5678, 4'b1000, 0, 1'b0);
`ifdef MEM_BUS_ERR_EN
    run_txn("rd_miss", 1'b0, 32'h4000_0000, 64'h0, 64'h5555_AAAA_5555_AAAA, 4'b0000, 0, 1'b1);
`else
    run_txn("rd_miss", 1'b0, 32'h4000_0000, 64'h0, 64'h5555_AAAA_5555_AAAA, 4'b0001, 0, 1'b0);
`endif

    // Held request on a wait-1 region: next acceptance only after 4 cycles.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0001_0000; mem_rdata = 64'h77;
    chk("b2b_ready0", req_ready, 1'b1);
    @(negedge clock);
    req_addr = 32'h8000_0000;
    chk("b2b_ready1", req_ready, 1'b0);
    chk("b2b_cs1", mem_cs, 4'b0010);
    @(negedge clock);
    chk("b2b_ready2", req_ready, 1'b0);
    chk("b2b_ignore_addr", mem_addr, 32'h0001_0000);
    chk("b2b_cs2", mem_cs, 4'b0010);
    @(negedge clock);
    chk("b2b_ready3", req_ready, 1'b0);
    chk("b2b_vld", rsp_valid, 1'b1);
    chk("b2b_rdata", rsp_rdata, 64'h77);
    @(negedge clock);
    chk("b2b_ready4", req_ready, 1'b1);
    @(negedge clock);
    req_valid = 1'b0;
    chk("b2b_second_addr", mem_addr, 32'h8000_0000);
    chk("b2b_second_cs", mem_cs, 4'b0100);
    repeat (5) @(negedge clock);
    chk("b2b_settle", req_ready, 1'b1);
    exp_rdata = 64'h77;

    // Asynchronous reset in the middle of a region2 read.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0010; mem_rdata = 64'h99;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("abort_cs_pre", mem_cs, 4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("abort_cs", mem_cs, 4'b0000);
    chk("abort_strb", {mem_re, mem_we}, 2'b00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rdata", rsp_rdata, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    exp_rdata = '0;
    for (int j = 0; j < 4; j++) begin
      chk("abort_no_vld", rsp_valid, 1'b0);
      @(negedge clock);
    end
    run_txn("rd_after_rst", 1'b0, 32'h0000_0020, 64'h0, 64'h0102_0304_0506_0708, 4'b0001, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 The block SHALL have parameters ADDR_WIDTH, 32, address width; DATA_WIDTH, 64, data width; NUM_REGIONS, 4, chip-select region count.
REQ-002 The block SHALL have parameters REGION_BASE, NUM_REGIONS*ADDR_WIDTH packed, region i base at bits [i*ADDR_WIDTH +: ADDR_WIDTH]; REGION_MASK, same packing, region i match mask; WAIT_STATES, NUM_REGIONS*4 packed, region i wait count at bits [i*4 +: 4].
REQ-003 Default region map SHALL be: region0 base 0x0000_0000 mask 0xFFFF_F000 wait 0 (RAM); region1 base 0x0001_0000 mask 0xFFFF_0000 wait 1 (ROM); region2 base 0x8000_0000 mask 0xFFFF_FF00 wait 3 (peripheral); region3 base 0xFFFF_FFFF mask 0xFFFF_FFFF wait 0 (spare).
REQ-004 Ports, in this order, SHALL be:
 clock  in  1  single clock, rising edge
 reset  in  1  asynchronous, active-low reset
 req_valid  in  1  CPU access request
 req_ready  out  1  request accepted this cycle when high with req_valid
 req_write  in  1  1=write, 0=read
 req_addr  in  ADDR_WIDTH  byte address
 req_size  in  2  00 byte, 01 half, 10 word, 11 dword
 req_wdata  in  DATA_WIDTH  write data
 rsp_valid  out  1  one-cycle completion pulse
 rsp_err  out  1  bus error, valid with rsp_valid
 rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
 mem_addr  out  ADDR_WIDTH  latched address to memories
 mem_size  out  2  latched size
 mem_wdata  out  DATA_WIDTH  latched write data
 mem_rdata  in  DATA_WIDTH  data from selected memory
 mem_cs  out  NUM_REGIONS  one-hot chip select
 mem_re  out  1  read enable
 mem_we  out  1  write strobe
 busy  out  1  high in any state other than IDLE

Function
REQ-005 State machine SHALL have states IDLE, ACCESS, DONE; req_ready = 1 only in IDLE.
REQ-006 In IDLE with req_valid=1, the block SHALL latch addr/size/wdata/write, decode the region, load wait counter with that region's WAIT_STATES, and enter ACCESS next edge.
REQ-007 Region i SHALL match when (req_addr & MASK_i) == BASE_i; when several match, the lowest index SHALL win.
REQ-008 In ACCESS, mem_cs SHALL be one-hot for the decoded region, mem_re SHALL equal ~write for the whole state, and the counter SHALL decrement once per cycle.
REQ-009 mem_we SHALL be high only during the ACCESS cycle where counter == 0 (exactly one-cycle strobe per write).
REQ-010 When counter == 0 in ACCESS, a read SHALL capture mem_rdata into rsp_rdata; the FSM SHALL enter DONE next edge.
REQ-011 In DONE, rsp_valid SHALL be 1 for exactly one cycle, mem_cs/mem_re/mem_we SHALL be 0, and the FSM SHALL return to IDLE.
REQ-012 Latency: request accepted at edge k with wait W SHALL yield rsp_valid high in the cycle after edge k+W+1; ACCESS lasts W+1 cycles; minimum transaction period is W+3 cycles.
REQ-013 rsp_rdata SHALL hold its value until the next read completes; for writes, rsp_rdata SHALL be unchanged.
REQ-014 req_valid while not in IDLE SHALL be ignored without side effects.
REQ-015 WAIT_STATES = 15 SHALL give 16 ACCESS cycles; the counter SHALL not wrap.

Reset
REQ-016 reset low SHALL immediately force state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_cs=0, mem_re=0, mem_we=0, mem_addr=0, mem_size=0, mem_wdata=0, busy=0, and counter=0, regardless of clock.
REQ-017 Reset asserted mid-ACCESS SHALL abort the transaction with no rsp_valid pulse; first request after reset release SHALL be accepted normally.

Configuration
REQ-018 With MEM_BUS_ERR_EN defined, an address matching no region SHALL skip ACCESS (no chip select, no strobes), go IDLE->DONE, and pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-019 Without MEM_BUS_ERR_EN, an unmatched address SHALL be routed to region 0 and rsp_err SHALL be tied 0.

Verification
REQ-020 Read region0 addr 0x0000_0010, mem_rdata=0x1122334455667788 -> mem_cs=0001 one cycle, rsp_valid 2 cycles after acceptance, rsp_rdata=0x1122334455667788.
REQ-021 Write region2 addr 0x8000_0004, wdata=0xAB -> mem_cs=0100 for 4 cycles, mem_we only in 4th, mem_re=0 throughout, rsp_valid 5 cycles after acceptance.
REQ-022 Read 0x0001_0000 with req_valid held high -> second request not accepted until IDLE; period 4 cycles for wait 1.
REQ-023 Read 0x4000_0000 with MEM_BUS_ERR_EN -> mem_cs=0, rsp_valid with rsp_err=1, rsp_rdata=0; without macro -> mem_cs=0001, rsp_err=0.
REQ-024 Assert reset during ACCESS of region2 read -> all strobes 0 immediately, no rsp_valid; next read of region0 completes in 2 cycles.
